// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 3-bit-opcode RISC sequencer.
//
// Contents:
//   OPCODE_W  - width of the opcode field; the opcode occupies the top
//               OPCODE_W bits of an instruction (instr[INSTR_W-1 -: OPCODE_W]).
//   opcode_t  - opcode encodings (ADD..MOV write the register file,
//               101/110 are reserved, 111 is HALT).
//   state_t   - sequencer state encoding, also exported on the debug port.
//
// Optional build macro used by the files that import this package:
//   CPU_SEQ_ILLEGAL_TRAP_EN - reserved opcodes trap to HALT instead of
//                             running as NOPs.
package cpu_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MOV  = 3'b100,
        OP_RSV5 = 3'b101,
        OP_RSV6 = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_sequencer_control_unit.sv
// control_unit: purely combinational opcode decoder for cpu_sequencer.
//
// Ports:
//   opcode     in   OPCODE_W  opcode field of the instruction register
//   alu_src    out  1         0 = register operand, 1 = immediate (MOV only)
//   writes_reg out  1         opcode writes the register file (000..100)
//   stop       out  1         DECODE must go to HALT instead of EXECUTE
//   trap       out  1         opcode is reserved and must raise 'illegal'
//
// Build macro: CPU_SEQ_ILLEGAL_TRAP_EN. When defined, reserved opcodes
// 101/110 assert stop and trap; otherwise they decode as NOPs and trap is 0.
module control_unit
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic                alu_src,
    output logic                writes_reg,
    output logic                stop,
    output logic                trap
);

    logic reserved;

    always_comb begin
        alu_src    = 1'b0;
        writes_reg = 1'b0;
        reserved   = 1'b0;
        stop       = 1'b0;
        case (opcode_t'(opcode))
            OP_ADD, OP_SUB, OP_AND, OP_OR: writes_reg = 1'b1;
            OP_MOV: begin
                writes_reg = 1'b1;
                alu_src    = 1'b1;
            end
            OP_RSV5, OP_RSV6: reserved = 1'b1;
            OP_HALT:          stop     = 1'b1;
            default:          stop     = 1'b0;
        endcase
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        trap = reserved;
        if (reserved) begin
            stop = 1'b1;
        end
`else
        // Reserved opcodes fall through as NOPs; nothing is flagged.
        trap = reserved & 1'b0;
`endif
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer.
//
// Ports:
//   clk, rst_n   clock; synchronous active-low reset
//   start        level; leaves IDLE when high
//   imem_req     out  fetch request, held in FETCH until imem_ack
//   imem_addr    out  fetch address (always equal to pc)
//   imem_ack     in   imem_rdata valid this cycle; ignored outside FETCH
//   imem_rdata   in   fetched instruction
//   ir           out  instruction register (valid from first DECODE cycle)
//   pc           out  program counter, wraps mod 2^PC_W
//   alu_src      out  registered in DECODE from the decoder
//   alu_en       out  one-cycle pulse in EXECUTE
//   reg_write    out  one-cycle pulse in WRITEBACK for writing opcodes
//   busy         out  high outside IDLE and HALT
//   halted       out  high in HALT
//   illegal      out  sticky reserved-opcode flag (trap build only)
//   retired      out  saturating count of completed instructions
//   state_dbg    out  current state encoding (cpu_pkg::state_t)
//
// Handshake: imem_req is a request held high with a stable imem_addr until
// the cycle imem_ack is sampled high; that cycle transfers imem_rdata into ir
// and drops the request. An ack while no request is pending has no effect.
//
// Build macro: CPU_SEQ_ILLEGAL_TRAP_EN. When defined, opcodes 101/110 halt
// the sequencer and set 'illegal'; otherwise they execute as NOPs.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    pc,
    output logic               alu_src,
    output logic               alu_en,
    output logic               reg_write,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired,
    output logic [2:0]         state_dbg
);

    state_t state;

    logic dec_alu_src;
    logic dec_writes_reg;
    logic dec_stop;
    logic dec_trap;

    // The decoder always looks at ir; ir is stable from DECODE through
    // WRITEBACK, which are the only states that consume decoder outputs.
    control_unit u_control_unit (
        .opcode     (ir[INSTR_W-1 -: OPCODE_W]),
        .alu_src    (dec_alu_src),
        .writes_reg (dec_writes_reg),
        .stop       (dec_stop),
        .trap       (dec_trap)
    );

    assign imem_addr = pc;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            ir        <= '0;
            retired   <= '0;
            alu_src   <= 1'b0;
            alu_en    <= 1'b0;
            reg_write <= 1'b0;
            imem_req  <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_src <= dec_alu_src;
                    if (dec_stop) begin
                        // HALT (or a trapped reserved opcode) retires nothing
                        // and leaves pc pointing at the stopping instruction.
                        state  <= ST_HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        if (dec_trap) begin
                            illegal <= 1'b1;
                        end
                    end else begin
                        state  <= ST_EXECUTE;
                        alu_en <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    alu_en    <= 1'b0;
                    reg_write <= dec_writes_reg;
                    state     <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    reg_write <= 1'b0;
                    pc        <= pc + 1'b1;
                    if (retired != {CNT_W{1'b1}}) begin
                        retired <= retired + 1'b1;
                    end
                    imem_req  <= 1'b1;
                    state     <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized self-checking bench for cpu_sequencer.
// A memory responder supplies instructions with random ack latency and
// spurious acks; an instruction-level reference model predicts the fetched
// addresses, the register writes, final pc/retired/illegal and cycle count.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    pc;
    logic               alu_src, alu_en, reg_write, busy, halted, illegal;
    logic [CNT_W-1:0]   retired;
    logic [2:0]         state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .pc(pc), .alu_src(alu_src), .alu_en(alu_en),
        .reg_write(reg_write), .busy(busy), .halted(halted),
        .illegal(illegal), .retired(retired), .state_dbg(state_dbg)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [7:0] mem [256];
    bit         resp_en = 1'b1;
    bit         spurious_en = 1'b1;
    bit         in_fetch = 1'b0;
    bit         patch0_pending = 1'b0;
    int         wait_left, req_cycles, max_delay = 0;
    logic [7:0] fetch_addr;
    int         delay_plan[$];
    int         del_used_q[$];
    int         req_len_q[$];
    logic [7:0] exp_addr_q[$];
    bit         mon_en = 1'b0;

    always @(negedge clk) begin
        if (resp_en) begin
            if (imem_req) begin
                if (!in_fetch) begin
                    in_fetch   = 1'b1;
                    req_cycles = 0;
                    fetch_addr = imem_addr;
                    wait_left  = (delay_plan.size() > 0) ? delay_plan.pop_front()
                                                         : $urandom_range(0, max_delay);
                    del_used_q.push_back(wait_left);
                    if (mon_en) begin
                        if (exp_addr_q.size() == 0) check_eq("fetch_extra", 1, 0);
                        else check_eq("fetch_addr", imem_addr, exp_addr_q.pop_front());
                    end
                end else begin
                    check_eq("addr_stable", imem_addr, fetch_addr);
                end
                req_cycles++;
                if (wait_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                    if (patch0_pending && imem_addr == 8'd0) begin
                        mem[0] = 8'hE0;
                        patch0_pending = 1'b0;
                    end
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 8'($urandom);
                    wait_left--;
                end
            end else begin
                if (in_fetch) req_len_q.push_back(req_cycles);
                in_fetch   = 1'b0;
                imem_ack   = spurious_en && ($urandom_range(0, 3) == 0);
                imem_rdata = 8'($urandom);
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [7:0] exp_q[$];
    int         wr_cyc_q[$];
    int         t0 = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("alu_en_with_reg_write", 32'(alu_en & reg_write), 0);
            if (reg_write) begin
                wr_cyc_q.push_back(cyc - t0);
                if (exp_q.size() == 0) check_eq("write_extra", 1, 0);
                else check_eq("write_ir", ir, exp_q.pop_front());
            end
            if (alu_en) check_eq("alu_src", alu_src, 32'(ir[7:5] == 3'b100));
        end
    end

    // ---------------- reference model ----------------
    int m_pc, m_ret, m_nonhalt;
    bit m_ill;

    task automatic model_run(input bit patch0);
        logic [7:0] mm [256];
        logic [7:0] instr;
        logic [2:0] op;
        bit p;
        int steps;
        p = patch0;
        steps = 0;
        for (int i = 0; i < 256; i++) mm[i] = mem[i];
        m_pc = 0; m_ret = 0; m_ill = 1'b0; m_nonhalt = 0;
        exp_q.delete();
        exp_addr_q.delete();
        while (steps < 2000) begin
            exp_addr_q.push_back(m_pc[7:0]);
            instr = mm[m_pc];
            op    = instr[7:5];
            if (p && m_pc == 0) begin
                mm[0] = 8'hE0;
                p = 1'b0;
            end
            if (op == 3'b111) break;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            if (op == 3'b101 || op == 3'b110) begin
                m_ill = 1'b1;
                break;
            end
`endif
            if (op <= 3'b100) exp_q.push_back(instr);
            m_pc = (m_pc + 1) % 256;
            if (m_ret < CNT_MAX) m_ret++;
            m_nonhalt++;
            steps++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        mon_en = 1'b0;
        start  = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
    endtask

    task automatic run_program(input bit patch0, output int cycles);
        int exp_cycles;
        reset_dut();
        model_run(patch0);
        patch0_pending = patch0;
        del_used_q.delete();
        req_len_q.delete();
        wr_cyc_q.delete();
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (!halted && (cyc - t0) < 6000) @(negedge clk);
        cycles = cyc - t0;
        check_eq("halt_reached", halted, 1);
        exp_cycles = 3 * m_nonhalt + 1;
        foreach (del_used_q[i]) exp_cycles += 1 + del_used_q[i];
        check_eq("fetch_count", del_used_q.size(), m_nonhalt + 1);
        check_eq("cycles", cycles, exp_cycles);
        check_eq("final_pc", pc, m_pc);
        check_eq("final_retired", retired, m_ret);
        check_eq("final_illegal", illegal, m_ill);
        check_eq("final_busy", busy, 0);
        check_eq("final_req", imem_req, 0);
        check_eq("final_state", state_dbg, ST_HALT);
        check_eq("writes_missing", exp_q.size(), 0);
        check_eq("fetches_missing", exp_addr_q.size(), 0);
        mon_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cycles, n;
        logic [2:0] op3;
        logic [4:0] lo;
        int len;

        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;

        // Reset values.
        reset_dut();
        check_eq("rst_pc", pc, 0);
        check_eq("rst_ir", ir, 0);
        check_eq("rst_retired", retired, 0);
        check_eq("rst_alu_src", alu_src, 0);
        check_eq("rst_alu_en", alu_en, 0);
        check_eq("rst_reg_write", reg_write, 0);
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_illegal", illegal, 0);
        check_eq("rst_state", state_dbg, ST_IDLE);

        // Directed program ADD, MOV, HALT with zero-wait ack.
        mem[0] = 8'h00; mem[1] = 8'h9F; mem[2] = 8'hE0;
        max_delay = 0;
        run_program(1'b0, cycles);
        check_eq("t1_cycles", cycles, 10);
        check_eq("t1_writes", wr_cyc_q.size(), 2);
        if (wr_cyc_q.size() == 2) begin
            check_eq("t1_first_write", wr_cyc_q[0], 3);
            check_eq("t1_write_gap", wr_cyc_q[1] - wr_cyc_q[0], 4);
        end
        check_eq("t1_pc", pc, 2);
        check_eq("t1_retired", retired, 2);

        // Start toggling in HALT has no effect.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = ~start;
            check_eq("halt_stays", halted, 1);
            check_eq("halt_no_req", imem_req, 0);
            @(negedge clk);
            start = ~start;
            check_eq("halt_state", state_dbg, ST_HALT);
        end
        start = 1'b0;

        // First fetch acked after 3 wait cycles.
        delay_plan.delete();
        delay_plan.push_back(3);
        run_program(1'b0, cycles);
        check_eq("t2_cycles", cycles, 13);
        if (req_len_q.size() > 0) check_eq("t2_req_len", req_len_q[0], 4);
        else check_eq("t2_req_len_seen", 0, 1);
        if (wr_cyc_q.size() == 2) begin
            check_eq("t2_first_write", wr_cyc_q[0], 6);
            check_eq("t2_second_write", wr_cyc_q[1], 10);
        end else check_eq("t2_writes", wr_cyc_q.size(), 2);

        // Reserved opcode 101 at address 0.
        mem[0] = 8'hA0; mem[1] = 8'hE0; mem[2] = 8'hE0;
        max_delay = 2;
        run_program(1'b0, cycles);
        check_eq("rsv_writes", wr_cyc_q.size(), 0);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        check_eq("rsv_illegal", illegal, 1);
        check_eq("rsv_pc", pc, 0);
        check_eq("rsv_retired", retired, 0);
`else
        check_eq("rsv_illegal", illegal, 0);
        check_eq("rsv_pc", pc, 1);
        check_eq("rsv_retired", retired, 1);
`endif

        // Random programs with random ack latency.
        max_delay = 3;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
            len = $urandom_range(3, 24);
            for (int i = 0; i < len; i++) begin
                op3 = 3'($urandom_range(0, 6));
                lo  = 5'($urandom);
                mem[i] = {op3, lo};
            end
            run_program(1'b0, cycles);
        end

        // 256 ORs: pc wraps to 0 where a HALT is patched in; retired saturates.
        for (int i = 0; i < 256; i++) begin
            lo = 5'($urandom);
            mem[i] = {3'b011, lo};
        end
        max_delay = 1;
        run_program(1'b1, cycles);
        check_eq("wrap_pc", pc, 0);
        check_eq("wrap_retired", retired, CNT_MAX);
        check_eq("wrap_writes", wr_cyc_q.size(), 256);

        // Reset while FETCH is waiting for ack; late ack must be ignored.
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
        mem[0] = 8'h1F; mem[1] = 8'h3F; mem[2] = 8'h55;
        reset_dut();
        delay_plan.delete();
        delay_plan.push_back(0);
        delay_plan.push_back(0);
        delay_plan.push_back(20);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(pc == 8'd2 && imem_req) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rf_reached_fetch", 32'(n < 100), 1);
        repeat (2) @(negedge clk);
        check_eq("rf_req_waiting", imem_req, 1);
        check_eq("rf_ir_before", ir, 8'h3F);
        rst_n    = 1'b0;
        resp_en  = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        check_eq("rf_req", imem_req, 0);
        check_eq("rf_pc", pc, 0);
        check_eq("rf_state", state_dbg, ST_IDLE);
        check_eq("rf_ir", ir, 0);
        check_eq("rf_busy", busy, 0);
        check_eq("rf_retired", retired, 0);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check_eq("late_ack_ir", ir, 0);
            check_eq("late_ack_state", state_dbg, ST_IDLE);
            check_eq("late_ack_req", imem_req, 0);
        end
        imem_ack = 1'b0;
        resp_en  = 1'b1;
        delay_plan.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 3-bit-opcode RISC core. It fetches instructions from instruction memory over a req/ack handshake and holds them in an instruction register. It steps each instruction through DECODE, EXECUTE and WRITEBACK, drives the program counter, and gates the register-file write enable. It sits between instruction memory and the register file/ALU datapath; opcode-to-control decoding comes from a `control_unit` instance.

## Interface
Parameters:
- `PC_W`, 8, program-counter / instruction-address width
- `INSTR_W`, 8, instruction width; opcode = `instr[INSTR_W-1 -: 3]`
- `CNT_W`, 16, retired-instruction counter width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  level; leaves IDLE when high
- `imem_req`  out  1  fetch request
- `imem_addr`  out  PC_W  fetch address (= pc)
- `imem_ack`  in  1  data valid on `imem_rdata` this cycle
- `imem_rdata`  in  INSTR_W  fetched instruction
- `ir`  out  INSTR_W  instruction register
- `pc`  out  PC_W  program counter
- `alu_src`  out  1  registered; 0 = register operand, 1 = immediate
- `alu_en`  out  1  one-cycle pulse in EXECUTE
- `reg_write`  out  1  one-cycle pulse in WRITEBACK, writing opcodes only
- `busy`  out  1  high in any state except IDLE and HALT
- `halted`  out  1  high in HALT
- `illegal`  out  1  sticky illegal-opcode flag (macro-dependent)
- `retired`  out  CNT_W  instructions completed, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Reset: state=IDLE and `pc`=0. `ir`, `retired`, `alu_src`, `alu_en`, `reg_write`, `imem_req`, `busy`, `halted` and `illegal` are all 0.
- IDLE -> FETCH when `start`=1.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - Request is held until `imem_ack`; the address stays stable while waiting.
  - On ack: `ir`<=`imem_rdata`, -> DECODE.
  - An ack without a request is ignored.
- DECODE: latch `alu_src` from the decoder.
  - Opcode 111 (HALT): -> HALT. `pc` is not incremented and `retired` is not counted.
  - Otherwise -> EXECUTE.
- EXECUTE: `alu_en`=1 for one cycle, -> WRITEBACK.
- WRITEBACK:
  - `reg_write`=1 only for opcodes 000–100 (ADD, SUB, AND, OR, MOV).
  - `pc`<=`pc`+1, wrapping mod 2^PC_W (max -> 0).
  - `retired`<=`retired`+1, saturating at all-ones.
  - -> FETCH.
- Opcodes 101/110: handling is set by the macro (see Configuration).
- HALT: terminal. `start` is ignored; only `rst_n` exits.
- Reset mid-operation (any state, including FETCH waiting for ack): all outputs reach reset values on the next edge. A late ack is ignored.

## Timing
- Minimum 4 cycles per instruction (FETCH with same-cycle ack, DECODE, EXECUTE, WRITEBACK). Each wait cycle on `imem_ack` adds one.
- `imem_req` rises the cycle after `start` is sampled in IDLE.
- `ir` is valid from the first DECODE cycle. `alu_src` is valid from EXECUTE until the next DECODE.
- `alu_en` and `reg_write` are never high in the same cycle.
- `halted` rises on the edge that leaves DECODE with opcode 111.

## Configuration
- `CPU_SEQ_ILLEGAL_TRAP_EN` defined:
  - Opcode 101/110 in DECODE -> HALT.
  - `illegal` set to 1 (sticky until reset).
  - `pc` and `retired` unchanged.
- Not defined:
  - 101/110 run as NOP through EXECUTE/WRITEBACK with `reg_write`=0.
  - `pc` and `retired` increment normally.
  - `illegal` tied to 0.

## Structure
- Shared package `cpu_pkg`: opcode constants (OP_ADD=000 … OP_MOV=100, OP_HALT=111), state enum/encoding, and the opcode field position.
- One sub-module: `control_unit` for opcode decode. The sequencer owns all registers and sequencing.

## Test plan
- Reset then `start`=1 with memory {ADD 0x00, MOV 0x9F, HALT 0xE0} and zero-wait ack:
  - `reg_write` pulses twice, 4 cycles apart.
  - `pc` ends at 2, `retired`=2, `halted`=1, `busy`=0.
- Ack delayed 3 cycles on the first fetch:
  - `imem_req` is held for 4 cycles with `imem_addr`=0.
  - The instruction takes 7 cycles in total.
- `pc` preset to 255 by executing 255 NOPs-equivalent ORs:
  - The next WRITEBACK wraps `pc` to 0.
  - `retired` saturates at 0xFFFF after 65535+ instructions (use CNT_W=4 to check saturation at 15).
- Opcode 101 at address 0:
  - With macro: HALT, `illegal`=1, `pc`=0, `retired`=0.
  - Without macro: `reg_write` never pulses, `pc`=1, `retired`=1.
- `rst_n`=0 asserted while FETCH is waiting for ack:
  - Next edge: `imem_req`=0, `pc`=0, state IDLE.
  - An ack arriving after reset leaves `ir`=0.
- In HALT, toggle `start` 10 times: `halted` stays 1 and `imem_req` stays 0.
